// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC scan controller: state encoding,
// channel count, frame byte-slot positions and a channel-pick helper.
package adc_pkg;

    localparam int unsigned NUM_CH  = 4;
    localparam int unsigned CH_W    = 2;
    localparam int unsigned ADDR_W  = 3;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned FRAME_W = NUM_CH * BYTE_W;

    // LSB position of each channel's byte inside the presented frame
    localparam int unsigned SLOT_CH0 = 24;
    localparam int unsigned SLOT_CH1 = 16;
    localparam int unsigned SLOT_CH2 = 8;
    localparam int unsigned SLOT_CH3 = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_START,
        S_WAIT_LO,
        S_WAIT_HI,
        S_READ,
        S_NEXT,
        S_PRESENT
    } scan_state_t;

    typedef struct packed {
        logic            found;
        logic [CH_W-1:0] idx;
    } ch_pick_t;

    // Lowest set mask bit at or above 'from'
    function automatic ch_pick_t pick_ch(input logic [NUM_CH-1:0] mask,
                                         input logic [CH_W:0]     from);
        ch_pick_t p;
        p = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(from))) begin
                p.found = 1'b1;
                p.idx   = CH_W'(i);
            end
        end
        return p;
    endfunction

    function automatic int unsigned slot_lsb(input logic [CH_W-1:0] ch);
        case (ch)
            CH_W'(0): slot_lsb = SLOT_CH0;
            CH_W'(1): slot_lsb = SLOT_CH1;
            CH_W'(2): slot_lsb = SLOT_CH2;
            default:  slot_lsb = SLOT_CH3;
        endcase
    endfunction

endpackage

// File: rtl/adc_clkdiv.sv
// Free-running ADC conversion clock: toggles every CLK_DIV system clocks.
module adc_clkdiv #(
    parameter int unsigned CLK_DIV = 8
) (
    input  logic clock,
    input  logic reset,
    output logic adc_clock
);

    localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_cnt;
    logic             r_adc_clk;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt     <= '0;
            r_adc_clk <= 1'b0;
        end else if (r_cnt == DIV_LAST) begin
            r_cnt     <= '0;
            r_adc_clk <= ~r_adc_clk;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

    assign adc_clock = r_adc_clk;

endmodule

// File: rtl/adc_scan_ctrl.sv
// Multi-channel ADC scan sequencer: selects, starts and reads each masked
// channel in ascending order, then presents a 4-byte frame via valid/ready.
module adc_scan_ctrl
    import adc_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 8,
    parameter int unsigned START_W     = 4,
    parameter int unsigned EOC_TIMEOUT = 255
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic [NUM_CH-1:0]  ch_mask,
    input  logic               eoc,
    input  logic [BYTE_W-1:0]  adc_data,
    output logic               adc_clock,
    output logic               start,
    output logic               ale,
    output logic               oe,
    output logic [ADDR_W-1:0]  address,
    output logic [FRAME_W-1:0] frame_data,
    output logic               frame_valid,
    input  logic               frame_ready,
    output logic               timeout_err,
    input  logic               err_clr
);

    localparam int unsigned      SW_W       = (START_W > 1) ? $clog2(START_W) : 1;
    localparam logic [SW_W-1:0]  START_LAST = SW_W'(START_W - 1);
    localparam int unsigned      TMO_W      = $clog2(EOC_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(EOC_TIMEOUT - 1);

    scan_state_t        r_state;
    logic               r_eoc_meta;
    logic               r_eoc_s;
    logic [NUM_CH-1:0]  r_mask;
    logic [CH_W-1:0]    r_ch;
    logic [SW_W-1:0]    r_start_cnt;
    logic [TMO_W-1:0]   r_tmo;
    logic               r_rd_phase;
    logic [BYTE_W-1:0]  r_bytes [NUM_CH];
    logic               r_start;
    logic               r_ale;
    logic               r_oe;
    logic [ADDR_W-1:0]  r_addr;
    logic [FRAME_W-1:0] r_frame;
    logic               r_fv;
    logic               r_err;

    ch_pick_t           w_pick_first;
    ch_pick_t           w_pick_next;
    logic [FRAME_W-1:0] w_frame;

    adc_clkdiv #(.CLK_DIV(CLK_DIV)) u_clkdiv (
        .clock     (clock),
        .reset     (reset),
        .adc_clock (adc_clock)
    );

    assign w_pick_first = pick_ch(ch_mask, '0);
    assign w_pick_next  = pick_ch(r_mask, (CH_W+1)'({1'b0, r_ch}) + (CH_W+1)'(1));

    always_comb begin
        w_frame = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_frame[slot_lsb(CH_W'(i)) +: BYTE_W] = r_bytes[i];
        end
    end

    // eoc is asynchronous to clock
    always_ff @(posedge clock) begin
        if (reset) begin
            r_eoc_meta <= 1'b0;
            r_eoc_s    <= 1'b0;
        end else begin
            r_eoc_meta <= eoc;
            r_eoc_s    <= r_eoc_meta;
        end
    end

    // Scan FSM; control strobes are registered alongside the state they belong to
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_mask      <= '0;
            r_ch        <= '0;
            r_start_cnt <= '0;
            r_tmo       <= '0;
            r_rd_phase  <= 1'b0;
            r_start     <= 1'b0;
            r_ale       <= 1'b0;
            r_oe        <= 1'b0;
            r_addr      <= '0;
            r_frame     <= '0;
            r_fv        <= 1'b0;
            r_err       <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) r_bytes[i] <= '0;
        end else begin
            r_ale   <= 1'b0;
            r_start <= 1'b0;
            r_oe    <= 1'b0;
            if (err_clr) r_err <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (enable && w_pick_first.found) begin
                        r_mask  <= ch_mask;
                        r_ch    <= w_pick_first.idx;
                        r_addr  <= ADDR_W'(w_pick_first.idx);
                        r_ale   <= 1'b1;
                        r_state <= S_SEL;
                        for (int i = 0; i < NUM_CH; i++) r_bytes[i] <= '0;
                    end
                end
                S_SEL: begin
                    r_start     <= 1'b1;
                    r_start_cnt <= '0;
                    r_state     <= S_START;
                end
                S_START: begin
                    if (r_start_cnt == START_LAST) begin
                        r_tmo   <= '0;
                        r_state <= S_WAIT_LO;
                    end else begin
                        r_start     <= 1'b1;
                        r_start_cnt <= r_start_cnt + SW_W'(1);
                    end
                end
                S_WAIT_LO: begin
                    if (!r_eoc_s) begin
                        r_tmo   <= r_tmo + TMO_W'(1);
                        r_state <= S_WAIT_HI;
                    end else if (r_tmo >= TMO_LAST) begin
                        r_bytes[r_ch] <= '0;
                        r_err         <= 1'b1;
                        r_state       <= S_NEXT;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                S_WAIT_HI: begin
                    if (r_eoc_s) begin
                        r_oe       <= 1'b1;
                        r_rd_phase <= 1'b0;
                        r_state    <= S_READ;
                    end else if (r_tmo >= TMO_LAST) begin
                        r_bytes[r_ch] <= '0;
                        r_err         <= 1'b1;
                        r_state       <= S_NEXT;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                S_READ: begin
                    if (!r_rd_phase) begin
                        r_oe       <= 1'b1;
                        r_rd_phase <= 1'b1;
                    end else begin
                        r_bytes[r_ch] <= adc_data;
                        r_state       <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (w_pick_next.found) begin
                        r_ch    <= w_pick_next.idx;
                        r_addr  <= ADDR_W'(w_pick_next.idx);
                        r_ale   <= 1'b1;
                        r_state <= S_SEL;
                    end else begin
                        r_frame <= w_frame;
                        r_fv    <= 1'b1;
                        r_state <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (frame_ready) begin
                        r_fv <= 1'b0;
                        if (enable && w_pick_first.found) begin
                            r_mask  <= ch_mask;
                            r_ch    <= w_pick_first.idx;
                            r_addr  <= ADDR_W'(w_pick_first.idx);
                            r_ale   <= 1'b1;
                            r_state <= S_SEL;
                            for (int i = 0; i < NUM_CH; i++) r_bytes[i] <= '0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign start       = r_start;
    assign ale         = r_ale;
    assign oe          = r_oe;
    assign address     = r_addr;
    assign frame_data  = r_frame;
    assign frame_valid = r_fv;
    assign timeout_err = r_err;

endmodule
